regfile_dumper: RTL and testbench

REGFILE_DUMPER -- requirements
Module: regfile_dumper

---
 rtl/regfile_dumper_pkg.sv | 15 +
 rtl/regfile_dumper.sv | 116 +++++++++++
 tb/tb_regfile_dumper.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dumper_pkg.sv
// Shared processor constants: register-file geometry and the dumper FSM encoding.
package regfile_dumper_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int REG_COUNT = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks a register-file read port from FIRST_REG to LAST_REG and streams each
// captured word out over a valid/ready channel, pulsing done at the end.
module regfile_dumper
   import regfile_dumper_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31,
   parameter bit ZERO_X0   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic [REG_IDX_W-1:0] rf_addr,
   input  logic [XLEN-1:0]      rf_rdata,
   output logic                 dump_valid,
   input  logic                 dump_ready,
   output logic [XLEN-1:0]      dump_data,
   output logic [REG_IDX_W-1:0] dump_idx,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           dbg_state
);

   localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
   localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

   dump_state_t          r_state;
   dump_state_t          w_next_state;
   logic [REG_IDX_W-1:0] r_idx;
   logic [REG_IDX_W-1:0] w_next_idx;
   logic                 r_dump_valid;
   logic                 w_next_valid;
   logic [XLEN-1:0]      r_dump_data;
   logic [XLEN-1:0]      w_next_data;
   logic [REG_IDX_W-1:0] r_dump_idx;
   logic [REG_IDX_W-1:0] w_next_dump_idx;
   logic                 w_handshake;

   // dump_valid/dump_ready: a word transfers on a rising edge where both are
   // high; while valid is high and ready low, dump_data and dump_idx hold.
   assign w_handshake = r_dump_valid & dump_ready;

   always_comb begin
      w_next_state    = r_state;
      w_next_idx      = r_idx;
      w_next_valid    = r_dump_valid;
      w_next_data     = r_dump_data;
      w_next_dump_idx = r_dump_idx;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_idx   = FIRST_IDX;
               w_next_state = READ;
            end
         end
         READ: begin
            if (abort) begin
               w_next_state = IDLE;
            end else begin
               w_next_data     = (ZERO_X0 && (r_idx == '0)) ? '0 : rf_rdata;
               w_next_dump_idx = r_idx;
               w_next_valid    = 1'b1;
               w_next_state    = PRESENT;
            end
         end
         PRESENT: begin
            // abort wins over a simultaneous handshake: no further words, no done
            if (abort) begin
               w_next_valid = 1'b0;
               w_next_state = IDLE;
            end else if (w_handshake) begin
               w_next_valid = 1'b0;
               if (r_idx == LAST_IDX) begin
                  w_next_state = DONE;
               end else begin
                  w_next_idx   = r_idx + 1'b1;
                  w_next_state = READ;
               end
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
            w_next_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_dump_valid <= 1'b0;
         r_dump_data  <= '0;
         r_dump_idx   <= '0;
      end else begin
         r_state      <= w_next_state;
         r_idx        <= w_next_idx;
         r_dump_valid <= w_next_valid;
         r_dump_data  <= w_next_data;
         r_dump_idx   <= w_next_dump_idx;
      end
   end

   assign rf_addr    = r_idx;
   assign dump_valid = r_dump_valid;
   assign dump_data  = r_dump_data;
   assign dump_idx   = r_dump_idx;
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: a behavioural register file feeds two
// instances, the default full-range dumper and a single-register (x5) dumper.
module tb_regfile_dumper;
   import regfile_dumper_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, abort, dump_ready;
   logic [4:0]  rf_addr, dump_idx;
   logic [31:0] rf_rdata, dump_data;
   logic        dump_valid, busy, done;
   logic [1:0]  dbg_state;

   logic        one_start, one_abort, one_ready;
   logic [4:0]  one_rf_addr, one_idx;
   logic [31:0] one_rf_rdata, one_data;
   logic        one_valid, one_busy, one_done;
   logic [1:0]  one_dbg_state;

   logic [31:0] rf_mem [REG_COUNT];
   assign rf_rdata     = rf_mem[rf_addr];
   assign one_rf_rdata = rf_mem[one_rf_addr];

   regfile_dumper dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .rf_addr(rf_addr), .rf_rdata(rf_rdata),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_data(dump_data), .dump_idx(dump_idx),
      .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   regfile_dumper #(.FIRST_REG(5), .LAST_REG(5), .ZERO_X0(1'b1)) dut_one (
      .clk(clk), .rst(rst), .start(one_start), .abort(one_abort),
      .rf_addr(one_rf_addr), .rf_rdata(one_rf_rdata),
      .dump_valid(one_valid), .dump_ready(one_ready),
      .dump_data(one_data), .dump_idx(one_idx),
      .busy(one_busy), .done(one_done), .dbg_state(one_dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      for (int i = 0; i < REG_COUNT; i++) rf_mem[i] = 32'h1000_0000 + i;
      rf_mem[0] = 32'hDEAD_BEEF;
   endtask

   task automatic fill_exp();
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
      for (int i = 1; i < 32; i++) exp_q.push_back(32'h1000_0000 + i);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; one_start = 1'b1;
      tick(); tick();
      n_tests++; if (dump_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", dump_valid); end
      n_tests++; if (dump_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dump_data); end
      n_tests++; if (dump_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", dump_idx); end
      n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
      n_tests++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
      n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      n_tests++; if (one_busy !== 1'b0 || one_rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_one: got busy %0b addr %0d want 0 0", one_busy, one_rf_addr); end
      rst = 1'b0; start = 1'b0; one_start = 1'b0;
      tick();
   endtask

   // Full 0..31 dump with ready held high: word k at cycle 2+2k, done at cycle 65.
   task automatic test_full_dump();
      int cyc, words, done_cnt, done_cyc, last_cyc;
      logic [31:0] e;
      preload(); fill_exp();
      dump_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      n_tests++; if (dump_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_latency_c1: got valid %0b busy %0b want 0 1", dump_valid, busy); end
      tick(); cyc = 2;
      n_tests++; if (dump_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency_c2: got valid %0b want 1", dump_valid); end
      words = 0; done_cnt = 0; done_cyc = 0; last_cyc = 0;
      while (cyc < 200) begin
         if (dump_valid && dump_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            n_tests++; if (dump_idx !== words[4:0]) begin n_fail++; $display("FAIL full_idx: got %0d want %0d", dump_idx, words); end
            n_tests++; if (dump_data !== e) begin n_fail++; $display("FAIL full_data[%0d]: got %h want %h", words, dump_data, e); end
            words++; last_cyc = cyc;
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (!busy) break;
         tick(); cyc++;
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_timeout: busy %0b after %0d cycles want 0", busy, cyc); end
      n_tests++; if (words != 32) begin n_fail++; $display("FAIL full_words: got %0d want 32", words); end
      n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
      n_tests++; if (done_cyc != 65 || done_cyc != last_cyc + 1) begin n_fail++; $display("FAIL full_done_cyc: got %0d (last word %0d) want 65 (64)", done_cyc, last_cyc); end
      dump_ready = 1'b0;
      tick();
   endtask

   task automatic test_single_reg();
      int cyc, words, done_cnt, done_cyc, stray;
      one_ready = 1'b1;
      one_start = 1'b1; tick(); cyc = 1;
      words = 0; done_cnt = 0; done_cyc = 0;
      while (cyc < 50) begin
         if (one_valid && one_ready) begin
            n_tests++; if (one_idx !== 5'd5 || one_data !== 32'h1000_0005) begin n_fail++; $display("FAIL single_word: got idx %0d data %h want 5 10000005", one_idx, one_data); end
            words++;
         end
         if (one_done) begin done_cnt++; done_cyc = cyc; one_start = 1'b0; end
         if (!one_busy) break;
         tick(); cyc++;
      end
      one_start = 1'b0;
      n_tests++; if (words != 1 || done_cnt != 1 || done_cyc != 3) begin n_fail++; $display("FAIL single_count: got words %0d done %0d at %0d want 1 1 at 3", words, done_cnt, done_cyc); end
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (one_valid || one_busy || one_done) stray++;
      end
      n_tests++; if (stray != 0) begin n_fail++; $display("FAIL single_restart: got %0d busy cycles want 0", stray); end
      one_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cyc, words, done_cnt, stall;
      logic [31:0] e;
      fill_exp();
      dump_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      words = 0; done_cnt = 0; stall = 0;
      while (cyc < 400) begin
         if (dump_valid) begin
            if (dump_idx == 5'd3 && stall < 7) begin
               n_tests++; if (dump_data !== 32'h1000_0003 || dump_idx !== 5'd3) begin n_fail++; $display("FAIL bp_stable[%0d]: got idx %0d data %h want 3 10000003", stall, dump_idx, dump_data); end
               stall++;
               dump_ready = 1'b0;
            end else begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
               n_tests++; if (dump_idx !== words[4:0] || dump_data !== e) begin n_fail++; $display("FAIL bp_order: got idx %0d data %h want %0d %h", dump_idx, dump_data, words, e); end
               words++;
               dump_ready = 1'b1;
            end
         end else begin
            dump_ready = 1'b0;
         end
         if (done) done_cnt++;
         if (!busy) break;
         tick(); cyc++;
      end
      dump_ready = 1'b0;
      n_tests++; if (stall != 7 || words != 32 || done_cnt != 1) begin n_fail++; $display("FAIL bp_summary: got stall %0d words %0d done %0d want 7 32 1", stall, words, done_cnt); end
      tick();
   endtask

   task automatic test_abort();
      int cyc, words, done_cnt, stray;
      logic aborted;
      fill_exp();
      dump_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      words = 0; done_cnt = 0; aborted = 1'b0;
      while (cyc < 200 && !aborted) begin
         if (dump_valid) begin
            n_tests++; if (dump_idx !== words[4:0]) begin n_fail++; $display("FAIL abort_order: got %0d want %0d", dump_idx, words); end
            words++;
            if (dump_idx == 5'd10) begin abort = 1'b1; aborted = 1'b1; end
         end
         if (done) done_cnt++;
         tick(); cyc++;
      end
      abort = 1'b0;
      n_tests++; if (busy !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 5'd10) begin n_fail++; $display("FAIL abort_idle: got busy %0b valid %0b idx %0d want 0 0 10", busy, dump_valid, dump_idx); end
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (dump_valid || done || busy) stray++;
         tick();
      end
      n_tests++; if (stray != 0 || done_cnt != 0 || words != 11) begin n_fail++; $display("FAIL abort_after: got stray %0d done %0d words %0d want 0 0 11", stray, done_cnt, words); end
      dump_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int cyc, words, done_cnt;
      logic [31:0] e;
      dump_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      while (cyc < 200) begin
         if (dump_valid && dump_idx == 5'd20) break;
         tick(); cyc++;
      end
      rst = 1'b1; tick(); rst = 1'b0;
      n_tests++; if (dump_valid !== 1'b0 || dump_data !== 32'h0 || dump_idx !== 5'd0) begin n_fail++; $display("FAIL midrst_out: got valid %0b data %h idx %0d want 0 0 0", dump_valid, dump_data, dump_idx); end
      n_tests++; if (busy !== 1'b0 || done !== 1'b0 || rf_addr !== 5'd0) begin n_fail++; $display("FAIL midrst_ctl: got busy %0b done %0b addr %0d want 0 0 0", busy, done, rf_addr); end
      fill_exp();
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      words = 0; done_cnt = 0;
      while (cyc < 200) begin
         if (dump_valid && dump_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            n_tests++; if (dump_idx !== words[4:0] || dump_data !== e) begin n_fail++; $display("FAIL midrst_redump: got idx %0d data %h want %0d %h", dump_idx, dump_data, words, e); end
            words++;
         end
         if (done) done_cnt++;
         if (!busy) break;
         tick(); cyc++;
      end
      n_tests++; if (words != 32 || done_cnt != 1) begin n_fail++; $display("FAIL midrst_count: got words %0d done %0d want 32 1", words, done_cnt); end
      dump_ready = 1'b0;
      tick();
   endtask

   // x7 is rewritten while word 6 is presented; the READ of x7 must see it.
   task automatic test_rf_write();
      int cyc, words;
      logic [31:0] e;
      preload(); fill_exp();
      exp_q[7] = 32'hCAFE_0007;
      dump_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0; cyc = 1;
      words = 0;
      while (cyc < 200) begin
         if (dump_valid && dump_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            if (dump_idx == 5'd6 || dump_idx == 5'd7) begin
               n_tests++; if (dump_data !== e) begin n_fail++; $display("FAIL rfwrite_word%0d: got %h want %h", dump_idx, dump_data, e); end
            end
            if (dump_idx == 5'd6) rf_mem[7] = 32'hCAFE_0007;
            words++;
         end
         if (!busy) break;
         tick(); cyc++;
      end
      n_tests++; if (words != 32) begin n_fail++; $display("FAIL rfwrite_words: got %0d want 32", words); end
      dump_ready = 1'b0;
      preload();
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
      one_start = 1'b0; one_abort = 1'b0; one_ready = 1'b0;
      preload();
      test_reset();
      test_full_dump();
      test_single_reg();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_rf_write();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
